// File: rtl/tsmap_port_arbiter.sv
// ============================================================================
// Module   : tsmap_port_arbiter
// Purpose  : Shares the read-only tsmap port of the 2-port DRAM between the
//            CPU and the DMA engine. The CPU has priority, and the DMA is
//            force-granted after MAX_DMA_WAIT consecutive denied cycles.
//            Each 1-cycle-latency response goes only to the requester that
//            issued it.
// Options  : TSMAP_SNOOP_EN adds snoop_* outputs that mirror every CPU
//            response, including the CPU address that produced it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tsmap_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int RAM_ADDR_W   = 13,
    parameter int DATA_W       = 32,
    parameter int MAX_DMA_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cpu_req_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_W-1:0]     cpu_rdata_o,
    output logic                  cpu_err_o,
    input  logic                  dma_req_i,
    input  logic [ADDR_W-1:0]     dma_addr_i,
    output logic                  dma_gnt_o,
    output logic                  dma_rvalid_o,
    output logic [DATA_W-1:0]     dma_rdata_o,
    output logic                  dma_err_o,
    output logic                  ram_cs_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0]     ram_rdata_i,
`ifdef TSMAP_SNOOP_EN
    output logic                  snoop_valid_o,
    output logic [ADDR_W-1:0]     snoop_addr_o,
    output logic [DATA_W-1:0]     snoop_rdata_o,
`endif
    output logic                  cpu_busy_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT = 4'(MAX_DMA_WAIT);

    owner_t                  owner;
    logic                    err_flag;
    logic [3:0]              starve_cnt;
    logic [RAM_ADDR_W-1:0]   addr_hold;

    logic                    dma_force;
    logic                    any_gnt;
    logic                    out_of_range;
    logic [ADDR_W-1:0]       gnt_addr;

    // DMA wins a contended cycle only once it has waited MAX_WAIT cycles.
    assign dma_force = cpu_req_i && dma_req_i && (starve_cnt == MAX_WAIT);
    assign cpu_gnt_o = rstn && cpu_req_i && !dma_force;
    assign dma_gnt_o = rstn && dma_req_i && (!cpu_req_i || dma_force);
    assign cpu_busy_o = cpu_gnt_o;
    assign any_gnt   = cpu_gnt_o || dma_gnt_o;
    assign gnt_addr  = dma_gnt_o ? dma_addr_i : cpu_addr_i;

    if (ADDR_W > RAM_ADDR_W) begin : g_range_check
        assign out_of_range = |gnt_addr[ADDR_W-1:RAM_ADDR_W];
    end else begin : g_range_full
        assign out_of_range = 1'b0;
    end

    // The RAM address follows the granted address and holds otherwise.
    assign ram_cs_o   = any_gnt && !out_of_range;
    assign ram_addr_o = ram_cs_o ? gnt_addr[RAM_ADDR_W-1:0] : addr_hold;

    // Track response ownership, the error flag, DMA starvation and the held address.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner      <= OWN_NONE;
            err_flag   <= 1'b0;
            starve_cnt <= 4'd0;
            addr_hold  <= '0;
        end else begin
            if (cpu_gnt_o)      owner <= OWN_CPU;
            else if (dma_gnt_o) owner <= OWN_DMA;
            else                owner <= OWN_NONE;
            err_flag <= any_gnt && out_of_range;

            if (!dma_req_i || dma_gnt_o) starve_cnt <= 4'd0;
            else if (starve_cnt != MAX_WAIT) starve_cnt <= starve_cnt + 4'd1;

            if (ram_cs_o) addr_hold <= gnt_addr[RAM_ADDR_W-1:0];
        end
    end

    // RAM data arrives in the response cycle. It is steered only to the owner and
    // is suppressed while reset is active, which discards an in-flight read.
    assign cpu_rvalid_o = rstn && (owner == OWN_CPU);
    assign dma_rvalid_o = rstn && (owner == OWN_DMA);
    assign cpu_err_o    = cpu_rvalid_o && err_flag;
    assign dma_err_o    = dma_rvalid_o && err_flag;
    assign cpu_rdata_o  = (cpu_rvalid_o && !err_flag) ? ram_rdata_i : '0;
    assign dma_rdata_o  = (dma_rvalid_o && !err_flag) ? ram_rdata_i : '0;

`ifdef TSMAP_SNOOP_EN
    logic [ADDR_W-1:0] snoop_addr;

    // Capture the CPU address at grant so it lines up with the CPU response.
    always_ff @(posedge clk) begin
        if (!rstn)          snoop_addr <= '0;
        else if (cpu_gnt_o) snoop_addr <= cpu_addr_i;
    end

    assign snoop_valid_o = cpu_rvalid_o;
    assign snoop_addr_o  = cpu_rvalid_o ? snoop_addr : '0;
    assign snoop_rdata_o = cpu_rdata_o;
`endif

endmodule

`default_nettype wire

// File: doc/tsmap_port_arbiter.md
Name: tsmap_port_arbiter

Overview:
- Owns the read-only second port of the 2-port DRAM, which holds the tag/shadow map (tsmap).
- Shares that port between the CPU and the DMA engine with per-requester request/grant handshakes.
- Gives the CPU priority, with a bounded-starvation guarantee for the DMA.
- Routes each 1-cycle-latency read response only to the requester that owns it; the other requester always sees zero data.

Parameters:
ADDR_W, 16, requester address width (word index)
RAM_ADDR_W, 13, tsmap RAM address width; legal address range is 0 to 2^RAM_ADDR_W-1
DATA_W, 32, read data width
MAX_DMA_WAIT, 4, consecutive denied DMA cycles before the DMA is force-granted (1 to 15)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
cpu_req_i  in  1  CPU read request, level, held until granted
cpu_addr_i  in  ADDR_W  CPU word address
cpu_gnt_o  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid_o  out  1  CPU response valid, one cycle after grant
cpu_rdata_o  out  DATA_W  CPU read data; 0 unless cpu_rvalid_o
cpu_err_o  out  1  CPU out-of-range error, qualified by cpu_rvalid_o
dma_req_i  in  1  DMA read request, level, held until granted
dma_addr_i  in  ADDR_W  DMA word address
dma_gnt_o  out  1  DMA request accepted this cycle (combinational)
dma_rvalid_o  out  1  DMA response valid
dma_rdata_o  out  DATA_W  DMA read data; 0 unless dma_rvalid_o
dma_err_o  out  1  DMA out-of-range error, qualified by dma_rvalid_o
ram_cs_o  out  1  tsmap RAM port chip select
ram_addr_o  out  RAM_ADDR_W  tsmap RAM port address
ram_rdata_i  in  DATA_W  tsmap RAM data, valid the cycle after ram_cs_o
cpu_busy_o  out  1  port is committed to the CPU this cycle (equals cpu_gnt_o); used for DMA throttling

Behaviour:
- Reset (synchronous, rstn=0):
  - owner register = NONE; starvation counter = 0; error flag = 0.
  - All registered outputs are 0: rvalid, rdata, err for both requesters.
  - An in-flight response is discarded; no rvalid is produced after reset releases.
- Arbitration (combinational, each cycle):
  - Only cpu_req_i: CPU granted.
  - Only dma_req_i: DMA granted.
  - Both requesting: CPU granted unless starve_cnt == MAX_DMA_WAIT, in which case DMA is granted and cpu_gnt_o=0. The CPU holds its request and is granted next cycle.
  - At most one grant per cycle. Grants are never issued while rstn=0.
- Starvation counter (4-bit):
  - Increments when dma_req_i && !dma_gnt_o, saturating at MAX_DMA_WAIT.
  - Clears on dma_gnt_o or when dma_req_i=0.
- Address check:
  - Granted address with any bit above RAM_ADDR_W-1 set is out of range.
  - Out-of-range: ram_cs_o=0, and the response cycle returns rvalid=1, err=1, rdata=0.
  - In range: ram_cs_o=1, ram_addr_o = granted address truncated to RAM_ADDR_W bits.
  - When there is no in-range grant, ram_addr_o holds its last value.
- Response pipeline (1-cycle latency):
  - Owner register takes values NONE/CPU/DMA; it is loaded with the granted requester, or NONE when there is no grant. The error flag is registered alongside it.
  - The cycle after a grant, the owner's rvalid=1, its rdata = ram_rdata_i (0 on error), and its err = error flag.
  - The non-owner's rvalid, rdata and err are all 0.
  - Back-to-back grants yield back-to-back responses. Ownership may alternate every cycle.
- Requester contract:
  - Address must be stable while req is high and ungranted.
  - Dropping req before grant is legal; it also clears the starvation counter.

Optional Feature:
TSMAP_SNOOP_EN
- Defined: adds the following ports.
  - snoop_valid_o  out  1
  - snoop_addr_o  out  ADDR_W
  - snoop_rdata_o  out  DATA_W
- On every CPU response, snoop_valid_o=1 with the CPU's granted address (registered at grant) and the CPU's rdata, in the same cycle as cpu_rvalid_o.
- All three snoop outputs are 0 otherwise and at reset. This lets the DMA reuse CPU lookups without taking the port.
- Undefined: the ports and their registers are absent. Behaviour is otherwise identical.

Test Plan:
- CPU-only read, RAM word 0x0005 = 0xDEADBEEF:
  - cpu_req=1, addr=0x0005 -> cpu_gnt same cycle, ram_cs=1, ram_addr=0x0005.
  - Next cycle: cpu_rvalid=1, cpu_rdata=0xDEADBEEF; dma_rdata=0.
- Contention: cpu_req and dma_req held high for 12 cycles, MAX_DMA_WAIT=4 -> grants CPU,CPU,CPU,CPU,DMA repeating; dma_gnt at cycles 4 and 9.
- Out-of-range DMA: dma_addr=0x2000, RAM_ADDR_W=13 -> dma_gnt=1, ram_cs=0; next cycle dma_rvalid=1, dma_err=1, dma_rdata=0.
- Alternating ownership: DMA-only at cycle 0 (addr 0x0010), CPU-only at cycle 1 (addr 0x0011) -> dma_rvalid at cycle 1 with RAM[0x10], cpu_rvalid at cycle 2 with RAM[0x11]; no cross-leakage of data.
- Reset mid-operation: CPU granted at cycle N, rstn=0 at cycle N+1 -> cpu_rvalid=0 at N+1 and N+2; starve_cnt=0 after reset.
- With TSMAP_SNOOP_EN: CPU read of 0x0123 -> snoop_valid=1, snoop_addr=0x0123, snoop_rdata=cpu_rdata, in the same cycle as cpu_rvalid.
